sa_fifo_ctrl_512x64: RTL

Valid/ready FIFO controller that sits directly in front of the 512x64 register-read-address RAM (`sa_ram_rws_512x64`) and owns all of its ports. It converts an upstream write stream into RAM writes and converts RAM reads into a downstream valid/ready stream. It tracks occupancy and absorbs the RAM's one-cycle read latency with a 2-entry output buffer. Sustained throughput is one word per cycle in each direction.

---
 rtl/sa_fifo_ctrl_512x64_pkg.sv | 21 ++
 rtl/sa_fifo_skid2.sv | 67 ++++++
 rtl/sa_fifo_ctrl_512x64.sv | 103 ++++++++++
 3 files changed

// File: rtl/sa_fifo_ctrl_512x64_pkg.sv
// ============================================================================
// sa_fifo_ctrl_512x64_pkg
//   Shared sizes and count types for the 512x64 RAM FIFO controller.
//   Rev 1.0
// ============================================================================
`default_nettype none

package sa_fifo_ctrl_512x64_pkg;

    localparam int FIFO_DEPTH = 512;
    localparam int FIFO_AW    = 9;
    localparam int FIFO_DW    = 64;
    localparam int RAM_CNT_W  = 10;
    localparam int FIFO_CNT_W = 11;

    typedef logic [RAM_CNT_W-1:0]  ram_cnt_t;
    typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

`default_nettype wire

// File: rtl/sa_fifo_skid2.sv
// ============================================================================
// sa_fifo_skid2
//   Two-entry flop FIFO that absorbs the RAM read latency.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sa_fifo_skid2
    import sa_fifo_ctrl_512x64_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          in_vld,
    input  logic [DW-1:0] in_pd,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_pd,
    output logic [1:0]    cnt
);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] ent0_q, ent0_d;
    logic [DW-1:0] ent1_q, ent1_d;
    logic          w_pop;
    logic [1:0]    w_slot;

    always_comb begin
        w_pop  = (cnt_q != 2'd0) & out_rdy;
        w_slot = cnt_q - {1'b0, w_pop};
        cnt_d  = cnt_q + {1'b0, in_vld} - {1'b0, w_pop};
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (w_pop) begin
            ent0_d = ent1_q;
        end
        // Incoming word lands in the first free slot after this cycle's pop.
        if (in_vld) begin
            if (w_slot == 2'd0) begin
                ent0_d = in_pd;
            end else begin
                ent1_d = in_pd;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign out_vld = (cnt_q != 2'd0);
    assign out_pd  = ent0_q;
    assign cnt     = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sa_fifo_ctrl_512x64.sv
// ============================================================================
// sa_fifo_ctrl_512x64
//   Valid/ready FIFO controller driving an external 512x64 1-cycle-read RAM.
//   Rev 1.0
// ============================================================================
`default_nettype none

module sa_fifo_ctrl_512x64
    import sa_fifo_ctrl_512x64_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  wr_pvld,
    output logic                  wr_prdy,
    input  logic [DW-1:0]         wr_pd,
    output logic                  rd_pvld,
    input  logic                  rd_prdy,
    output logic [DW-1:0]         rd_pd,
    output logic [FIFO_CNT_W-1:0] fifo_count,
    output logic [AW-1:0]         ram_ra,
    output logic                  ram_re,
    input  logic [DW-1:0]         ram_dout,
    output logic [AW-1:0]         ram_wa,
    output logic                  ram_we,
    output logic [DW-1:0]         ram_di,
    input  logic [31:0]           pwrbus_ram_pd,
    output logic [31:0]           ram_pwrbus_ram_pd
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    ram_cnt_t      ram_cnt_q, ram_cnt_d;
    logic          full_q, full_d;
    logic          inflight_q, inflight_d;

    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic [2:0]    w_credit;
    logic [1:0]    w_out_cnt;
    logic          w_out_vld;

    // Credit counts free output-buffer slots, including the one a pop frees now.
    always_comb begin
        w_push     = wr_pvld & ~full_q;
        w_pop      = w_out_vld & rd_prdy;
        w_credit   = 3'd2 - {1'b0, w_out_cnt} - {2'b0, inflight_q} + {2'b0, w_pop};
        w_issue    = (ram_cnt_q != '0) && (w_credit != 3'd0);
        wr_ptr_d   = wr_ptr_q + AW'(w_push);
        rd_ptr_d   = rd_ptr_q + AW'(w_issue);
        ram_cnt_d  = ram_cnt_q + RAM_CNT_W'(w_push) - RAM_CNT_W'(w_issue);
        full_d     = (ram_cnt_d == RAM_CNT_W'(DEPTH));
        inflight_d = w_issue;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            full_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            full_q     <= full_d;
            inflight_q <= inflight_d;
        end
    end

    // RAM data is captured exactly in the cycle after the read was issued.
    sa_fifo_skid2 #(
        .DW (DW)
    ) u_skid2 (
        .clk     (clk),
        .reset_  (reset_),
        .in_vld  (inflight_q),
        .in_pd   (ram_dout),
        .out_vld (w_out_vld),
        .out_rdy (rd_prdy),
        .out_pd  (rd_pd),
        .cnt     (w_out_cnt)
    );

    assign wr_prdy           = ~full_q;
    assign rd_pvld           = w_out_vld;
    assign ram_ra            = rd_ptr_q;
    assign ram_re            = w_issue;
    assign ram_wa            = wr_ptr_q;
    assign ram_we            = w_push;
    assign ram_di            = wr_pd;
    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
    assign fifo_count        = FIFO_CNT_W'(ram_cnt_q) + FIFO_CNT_W'(inflight_q)
                             + FIFO_CNT_W'(w_out_cnt);

endmodule

`default_nettype wire
